// File: rtl/vad_preroll_buffer.sv
// Pre-roll ring buffer for VAD-gated audio: keeps the last PREROLL samples while idle, then
// streams pre-roll + live audio + hangover. Optional peak_level output with `define VAD_PREROLL_PEAK_EN.
module vad_preroll_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 24000,
  parameter int PREROLL    = 8000,
  parameter int HANGOVER   = 4000,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  input  logic                  vad_active,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic [1:0]            state,
  output logic [ADDR_WIDTH:0]   fill_level,
  output logic                  overflow,
  output logic [15:0]           drop_count
`ifdef VAD_PREROLL_PEAK_EN
  ,
  output logic [ADDR_WIDTH:0]   peak_level
`endif
);

  localparam int CW = $clog2(HANGOVER + 1);
  localparam logic [ADDR_WIDTH:0] FILL_DEPTH   = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] FILL_PREROLL = (ADDR_WIDTH + 1)'(PREROLL);
  localparam logic [ADDR_WIDTH:0] FILL_ONE     = (ADDR_WIDTH + 1)'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_HANG   = 2'd2,
    S_DRAIN  = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]     fill_q, fill_d;
  logic [CW-1:0]           hang_q, hang_d;
  logic                    ovf_q, ovf_d;
  logic [15:0]             drops_q, drops_d;
  logic                    byp_q;
  logic [DATA_WIDTH-1:0]   byp_data_q, rd_data_q;
  logic                    wr_en, rd_en, pop, drop;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
    return (p == ADDR_WIDTH'(DEPTH - 1)) ? '0 : p + ADDR_WIDTH'(1);
  endfunction

  assign out_valid = (state_q != S_IDLE) && (fill_q != '0);
  assign rd_en     = out_valid && out_ready;
  assign out_last  = out_valid && (state_q == S_DRAIN) && (fill_q == FILL_ONE);
  assign out_data  = out_valid ? (byp_q ? byp_data_q : rd_data_q) : '0;
  assign state      = state_q;
  assign fill_level = fill_q;
  assign overflow   = ovf_q;
  assign drop_count = drops_q;

  always_comb begin
    state_d = state_q;
    hang_d  = hang_q;
    wr_en   = 1'b0;
    pop     = rd_en;
    drop    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        wr_en = in_valid;
        // Once the pre-roll window is full, every new sample evicts the oldest one.
        pop   = in_valid && (fill_q >= FILL_PREROLL);
        if (vad_active) state_d = S_ACTIVE;
      end
      S_ACTIVE, S_HANG: begin
        wr_en = in_valid && ((fill_q != FILL_DEPTH) || rd_en);
        drop  = in_valid && !wr_en;
        if (state_q == S_ACTIVE) begin
          if (!vad_active) begin
            state_d = S_HANG;
            hang_d  = CW'(HANGOVER);
          end
        end else if (vad_active) begin
          state_d = S_ACTIVE;
        end else if (in_valid) begin
          hang_d = hang_q - CW'(1);
          if (hang_q == CW'(1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if ((fill_q == '0) || (rd_en && (fill_q == FILL_ONE))) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    fill_d = fill_q;
    if (wr_en && !pop)      fill_d = fill_q + FILL_ONE;
    else if (!wr_en && pop) fill_d = fill_q - FILL_ONE;
  end

  assign wr_ptr_d = wr_en ? ptr_inc(wr_ptr_q) : wr_ptr_q;
  assign rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
  assign ovf_d    = ovf_q | drop;
  assign drops_d  = (drop && (drops_q != 16'hFFFF)) ? drops_q + 16'd1 : drops_q;

  // Read-before-write RAM; a write landing on the next read address is forwarded via byp_q.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= in_data;
    rd_data_q <= mem[rd_ptr_d];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
      hang_q     <= '0;
      ovf_q      <= 1'b0;
      drops_q    <= '0;
      byp_q      <= 1'b0;
      byp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fill_q     <= fill_d;
      hang_q     <= hang_d;
      ovf_q      <= ovf_d;
      drops_q    <= drops_d;
      byp_q      <= wr_en && (wr_ptr_q == rd_ptr_d);
      byp_data_q <= in_data;
    end
  end

`ifdef VAD_PREROLL_PEAK_EN
  logic [ADDR_WIDTH:0] peak_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              peak_q <= '0;
    else if (fill_q > peak_q) peak_q <= fill_q;
  end
  assign peak_level = peak_q;
`endif

endmodule

// File: tb/tb_vad_preroll_buffer.sv
// Bench for vad_preroll_buffer: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_vad_preroll_buffer;
  localparam int DW = 16, DEPTH = 16, PREROLL = 4, HANG = 3, AW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          vad_active = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_valid, out_last, overflow;
  logic [1:0]    state;
  logic [AW:0]   fill_level;
  logic [15:0]   drop_count;
`ifdef VAD_PREROLL_PEAK_EN
  logic [AW:0]   peak_level;
`endif

  vad_preroll_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PREROLL(PREROLL), .HANGOVER(HANG)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .vad_active(vad_active),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .state(state), .fill_level(fill_level), .overflow(overflow), .drop_count(drop_count)
`ifdef VAD_PREROLL_PEAK_EN
    , .peak_level(peak_level)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode, a queue of stored samples and simple counters.
  int m_mode = 0, m_hang = 0, m_ovf = 0, m_drops = 0, m_peak = 0;
  int m_q[$];

  function automatic int e_valid();
    return (m_mode != 0 && m_q.size() > 0) ? 1 : 0;
  endfunction
  function automatic int e_data();
    return (e_valid() != 0) ? m_q[0] : 0;
  endfunction
  function automatic int e_last();
    return (m_mode == 3 && m_q.size() == 1) ? 1 : 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_hang = 0; m_ovf = 0; m_drops = 0; m_peak = 0;
      m_q.delete();
    end else begin
      automatic bit rd = (e_valid() != 0) && out_ready;
      if (m_q.size() > m_peak) m_peak = m_q.size();
      case (m_mode)
        0: begin
          if (in_valid) begin
            m_q.push_back(int'(in_data));
            if (m_q.size() > PREROLL) void'(m_q.pop_front());
          end
          if (vad_active) m_mode = 1;
        end
        1, 2: begin
          if (rd) void'(m_q.pop_front());
          if (in_valid) begin
            if (m_q.size() < DEPTH) m_q.push_back(int'(in_data));
            else begin
              m_ovf = 1;
              if (m_drops < 65535) m_drops++;
            end
          end
          if (m_mode == 1) begin
            if (!vad_active) begin m_mode = 2; m_hang = HANG; end
          end else if (vad_active) m_mode = 1;
          else if (in_valid) begin
            m_hang--;
            if (m_hang == 0) m_mode = 3;
          end
        end
        default: begin
          if (rd) void'(m_q.pop_front());
          if (m_q.size() == 0) m_mode = 0;
        end
      endcase
    end
  end

  logic [DW-1:0] got[$];
  bit            hold_prev = 1'b0;
  logic [DW-1:0] hold_data = '0;

  always @(negedge clk) begin
    if (chk_on) begin
      check("state", state, m_mode);
      check("fill_level", fill_level, m_q.size());
      check("out_valid", out_valid, e_valid());
      check("out_data", out_data, e_data());
      check("out_last", out_last, e_last());
      check("overflow", overflow, m_ovf);
      check("drop_count", drop_count, m_drops);
`ifdef VAD_PREROLL_PEAK_EN
      check("peak_level", peak_level, m_peak);
`endif
      if (hold_prev && rst_n) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, hold_data);
      end
      hold_prev = rst_n && out_valid && !out_ready;
      hold_data = out_data;
      if (rst_n && out_valid && out_ready) got.push_back(out_data);
    end
  end

  task automatic cyc(input logic iv, input logic [DW-1:0] d, input logic vad, input logic rdy);
    in_valid = iv; in_data = d; vad_active = vad; out_ready = rdy;
    @(posedge clk); #1;
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1 chk_on = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_state", state, 0);
    check("rst_fill", fill_level, 0);
    check("rst_valid", out_valid, 0);

    // Pre-roll: 1..10 in IDLE keeps 7..10, then live 11.. streamed in order
    for (int i = 1; i <= 10; i++) cyc(1'b1, DW'(i), 1'b0, 1'b0);
    check("pre_fill", fill_level, 4);
    check("pre_idle_valid", out_valid, 0);
    got.delete();
    cyc(1'b0, '0, 1'b1, 1'b1);
    check("pre_first", out_data, 7);
    for (int i = 11; i <= 20; i++) cyc(1'b1, DW'(i), 1'b1, 1'b1);
    repeat (4) cyc(1'b0, '0, 1'b1, 1'b1);
    check("pre_cnt", got.size(), 14);
    check("pre_g0", got[0], 7);
    check("pre_g3", got[3], 10);
    check("pre_g4", got[4], 11);
    check("pre_g13", got[13], 20);
    cyc(1'b1, 16'd21, 1'b1, 1'b0);
    check("lat_valid", out_valid, 1);
    check("lat_data", out_data, 21);

    // Hangover: 3 samples stored, next 2 ignored, last stored sample flagged
    cyc(1'b0, '0, 1'b0, 1'b0);
    check("hang_state", state, 2);
    for (int i = 22; i <= 24; i++) cyc(1'b1, DW'(i), 1'b0, 1'b0);
    check("drain_state", state, 3);
    cyc(1'b1, 16'd25, 1'b0, 1'b0);
    cyc(1'b1, 16'd26, 1'b0, 1'b0);
    check("drain_fill", fill_level, 4);
    got.delete();
    repeat (3) cyc(1'b0, '0, 1'b0, 1'b1);
    check("last_flag", out_last, 1);
    check("last_data", out_data, 24);
    cyc(1'b0, '0, 1'b0, 1'b1);
    check("end_state", state, 0);
    check("end_fill", fill_level, 0);
    check("drain_g3", got[3], 24);

    // Overflow, then full with simultaneous read/write
    for (int i = 101; i <= 104; i++) cyc(1'b1, DW'(i), 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) cyc(1'b1, DW'(105 + i), 1'b1, 1'b0);
    check("ovf_fill", fill_level, 16);
    check("ovf_drops", drop_count, 8);
    check("ovf_flag", overflow, 1);
    got.delete();
    for (int i = 0; i < 5; i++) cyc(1'b1, DW'(200 + i), 1'b1, 1'b1);
    check("full_fill", fill_level, 16);
    check("full_drops", drop_count, 8);
    cyc(1'b0, '0, 1'b0, 1'b1);
    for (int i = 300; i <= 302; i++) cyc(1'b1, DW'(i), 1'b0, 1'b1);
    for (int k = 0; k < 100 && state != 2'd0; k++) cyc(1'b0, '0, 1'b0, 1'b1);
    check("ovf_done", state, 0);
    check("ovf_cnt", got.size(), 24);
    check("ovf_g3", got[3], 104);
    check("ovf_g4", got[4], 105);
    check("ovf_g15", got[15], 116);
    check("ovf_g16", got[16], 200);
    check("ovf_g23", got[23], 302);

    // Backpressure with random ready and sparse input
    cyc(1'b0, '0, 1'b1, 1'b0);
    for (int k = 0; k < 60; k++)
      cyc(1'($urandom_range(0, 1)), DW'(500 + k), 1'b1, 1'($urandom_range(0, 1)));
    cyc(1'b0, '0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) cyc(1'b1, DW'(600 + k), 1'b0, 1'($urandom_range(0, 1)));
    for (int k = 0; k < 100 && state != 2'd0; k++) cyc(1'b0, '0, 1'b0, 1'($urandom_range(0, 1)));
    check("bp_done", state, 0);

    // Reset mid-burst: outputs clear without a clock edge
    cyc(1'b0, '0, 1'b1, 1'b0);
    cyc(1'b1, 16'd700, 1'b1, 1'b0);
    cyc(1'b1, 16'd701, 1'b1, 1'b0);
    check("pre_rst_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_state", state, 0);
    check("mid_rst_fill", fill_level, 0);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_data", out_data, 0);
    check("mid_rst_last", out_last, 0);
    check("mid_rst_ovf", overflow, 0);
    check("mid_rst_drops", drop_count, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(1'b0, '0, 1'b0, 1'b0);
    check("post_rst_state", state, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vad_preroll_buffer.md
Name: vad_preroll_buffer

Overview:
Parametrised audio ring buffer that sits between the sample front-end and the VAD-gated feature path. While idle it keeps the most recent PREROLL samples, so speech onsets are not clipped. When VAD fires it streams the pre-roll followed by live audio over a valid/ready interface, then keeps streaming for a hangover window after VAD falls. It ends the burst with an out_last marker.

Parameters:
DATA_WIDTH, 16, sample width in bits
DEPTH, 24000, storage depth in samples (>= 2)
PREROLL, 8000, samples retained while idle (1 <= PREROLL < DEPTH)
HANGOVER, 4000, input samples still captured after vad_active falls (>= 1)
ADDR_WIDTH, $clog2(DEPTH), pointer width (derived)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
in_data  in  DATA_WIDTH  input sample
in_valid  in  1  one-cycle strobe per input sample
vad_active  in  1  level from the VAD, synchronous to clk
out_data  out  DATA_WIDTH  oldest stored sample; 0 when out_valid=0
out_valid  out  1  out_data holds a sample
out_ready  in  1  consumer accepts; transfer = out_valid & out_ready
out_last  out  1  final sample of a burst (qualified by out_valid)
state  out  2  0=IDLE 1=ACTIVE 2=HANG 3=DRAIN
fill_level  out  ADDR_WIDTH+1  samples currently stored
overflow  out  1  sticky: a sample was dropped since reset
drop_count  out  16  dropped samples, saturates at 16'hFFFF

Behaviour:
- Reset (async assert, sync release): state=IDLE, wr_ptr=rd_ptr=0, fill_level=0, out_valid=0, out_data=0, out_last=0, overflow=0, drop_count=0. Memory contents are not cleared.
- Pointers wrap from DEPTH-1 to 0; DEPTH need not be a power of 2.
- Latency: a sample written in cycle N is visible on out_data/out_valid in cycle N+1. out_data is first-word-fall-through from rd_ptr.
- IDLE:
  - Each in_valid writes the sample.
  - If fill_level < PREROLL, fill_level increments.
  - Otherwise rd_ptr advances in the same cycle (oldest sample discarded) and fill_level stays at PREROLL.
  - out_valid=0.
  - vad_active=1 -> ACTIVE on the next edge. The write in that same cycle still follows IDLE rules.
- ACTIVE:
  - Writes accepted while fill_level < DEPTH.
  - out_valid = (fill_level != 0).
  - vad_active=0 -> HANG; the hangover counter loads HANGOVER.
- HANG:
  - Writes continue as in ACTIVE.
  - The counter decrements on each in_valid, whether the sample is stored or dropped.
  - vad_active=1 -> ACTIVE (counter discarded).
  - When the counter reaches 0 -> DRAIN.
- DRAIN:
  - in_valid samples are ignored: not stored, not counted as drops.
  - vad_active is ignored.
  - Reading continues. out_last=1 when out_valid=1 and fill_level==1.
  - Transfer of that sample -> IDLE with fill_level=0. If vad_active is still 1, the next state is ACTIVE on the following edge.
- Write and read in the same cycle:
  - Both occur; fill_level is unchanged.
  - When full (fill_level=DEPTH): the read frees a slot, so the write is accepted, no drop.
  - When empty: out_valid was 0, so only the write occurs and fill_level becomes 1.
- Overflow: in_valid in ACTIVE/HANG with fill_level==DEPTH and no transfer that cycle -> sample dropped, overflow<=1, drop_count += 1 (saturating).
- Handshake: once out_valid=1, out_valid and out_data stay stable until the transfer. fill_level never drops to 0 except by a transfer, so out_valid cannot fall without one.
- Reset mid-operation: immediate return to reset values. An in-flight burst is abandoned and no out_last is produced.

Optional Feature:
VAD_PREROLL_PEAK_EN:
- Defined: adds output peak_level [ADDR_WIDTH:0], the maximum fill_level since reset. It updates one cycle after fill_level changes and resets to 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
All scenarios use DEPTH=16, PREROLL=4, HANGOVER=3.
- Reset: assert rst_n=0 mid-stream -> all outputs 0 and state=0 in the same cycle, with no clock edge needed.
- Pre-roll: in IDLE feed samples 1..10, then vad_active=1 with out_ready=1 -> out_data sequence 7,8,9,10, then live samples 11,12,... with 1-cycle latency.
- Hangover/drain: while ACTIVE drop vad_active, then feed 3 samples and 2 more -> first 3 stored, last 2 ignored. The final stored sample carries out_last=1, then state=0 and fill_level=0.
- Overflow: ACTIVE after 4-sample pre-roll, out_ready=0, feed 20 samples -> fill_level=16, drop_count=8, overflow=1. The drain yields the 4 pre-roll samples, then the first 12 live samples.
- Full simultaneous: fill_level=16, in_valid=1 and out_ready=1 for 5 cycles -> fill_level stays 16, drop_count unchanged.
- Backpressure: toggle out_ready pseudo-randomly during ACTIVE -> out_data stable while out_valid=1 and out_ready=0. There is no loss or duplication against a reference queue.
